stream_divider: RTL and testbench

- Fully pipelined signed fixed-point divider for valid-only streams. It is the inverse of the fixed-point stream multiplier.
- Computes the Q1.(DATA_WIDTH-1) quotient of numerator and denominator.
- Accepts one beat per clock with no backpressure. It sits in the same DSP datapaths, for example for normalisation and gain removal.

---
 rtl/stream_divider.sv | 111 +++++++++++
 tb/tb_stream_divider.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_divider.sv
// Pipelined signed Q1.(DATA_WIDTH-1) stream divider built from restoring-division stages.
// Define STREAM_DIVIDER_ROUND_EN for round-half-away-from-zero (one extra stage of latency).
module stream_divider #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] data_0_i_tdata,
  input  logic                  data_0_i_tvalid,
  input  logic [DATA_WIDTH-1:0] data_1_i_tdata,
  input  logic                  data_1_i_tvalid,
  output logic [DATA_WIDTH-1:0] data_o_tdata,
  output logic                  data_o_tvalid,
  output logic                  div_zero_o
);

  localparam int W = DATA_WIDTH;
`ifdef STREAM_DIVIDER_ROUND_EN
  localparam int NS = W;
`else
  localparam int NS = W - 1;
`endif
  localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  logic [W-1:0] nabs_c, dabs_c;
  logic         sgn_c, zero_c, ovf_c, eno_c;

  logic [NS:0]  v_s, sgn_s, zero_s, nsgn_s, ovf_s, eno_s;
  logic [W-1:0] rem_s  [0:NS-1];
  logic [W-1:0] dmag_s [0:NS-1];
  logic [W-1:0] q_s    [0:NS];
  logic [W:0]   shl_c  [1:NS];
  logic [W:0]   diff_c [1:NS];
  logic [W-1:0] mag_c, res_c;

  // Unsigned magnitude of -2^(W-1) wraps to 2^(W-1), which fits W unsigned bits.
  always_comb begin
    nabs_c = data_0_i_tdata[W-1] ? (-data_0_i_tdata) : data_0_i_tdata;
    dabs_c = data_1_i_tdata[W-1] ? (-data_1_i_tdata) : data_1_i_tdata;
    sgn_c  = data_0_i_tdata[W-1] ^ data_1_i_tdata[W-1];
    zero_c = (data_1_i_tdata == '0);
    ovf_c  = (nabs_c >= dabs_c);
    eno_c  = (nabs_c == dabs_c) && sgn_c && !zero_c;
  end

  always_comb begin
    for (int i = 1; i <= NS; i++) begin
      shl_c[i]  = {rem_s[i-1], 1'b0};
      diff_c[i] = shl_c[i] - {1'b0, dmag_s[i-1]};
    end
  end

  // Sign, divide-by-zero and range overrides take priority over the magnitude.
  always_comb begin
    mag_c = '0;
    res_c = '0;
`ifdef STREAM_DIVIDER_ROUND_EN
    mag_c = {1'b0, q_s[NS][W-1:1]} + {{(W-1){1'b0}}, q_s[NS][0]};
`else
    mag_c = q_s[NS];
`endif
    if (zero_s[NS])
      res_c = nsgn_s[NS] ? MINV : MAXV;
    else if (eno_s[NS])
      res_c = MINV;
    else if (ovf_s[NS] || (mag_c == MINV))
      res_c = sgn_s[NS] ? MINV : MAXV;
    else
      res_c = sgn_s[NS] ? (-mag_c) : mag_c;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      v_s    <= '0;
      sgn_s  <= '0;
      zero_s <= '0;
      nsgn_s <= '0;
      ovf_s  <= '0;
      eno_s  <= '0;
      for (int i = 0; i < NS; i++) begin
        rem_s[i]  <= '0;
        dmag_s[i] <= '0;
      end
      for (int i = 0; i <= NS; i++) q_s[i] <= '0;
      data_o_tdata  <= '0;
      data_o_tvalid <= 1'b0;
      div_zero_o    <= 1'b0;
    end else begin
      v_s    <= {v_s[NS-1:0], data_0_i_tvalid & data_1_i_tvalid};
      sgn_s  <= {sgn_s[NS-1:0], sgn_c};
      zero_s <= {zero_s[NS-1:0], zero_c};
      nsgn_s <= {nsgn_s[NS-1:0], data_0_i_tdata[W-1]};
      ovf_s  <= {ovf_s[NS-1:0], ovf_c};
      eno_s  <= {eno_s[NS-1:0], eno_c};
      rem_s[0]  <= nabs_c;
      dmag_s[0] <= dabs_c;
      q_s[0]    <= '0;
      for (int i = 1; i <= NS; i++)
        q_s[i] <= {q_s[i-1][W-2:0], ~diff_c[i][W]};
      for (int i = 1; i < NS; i++) begin
        rem_s[i]  <= diff_c[i][W] ? shl_c[i][W-1:0] : diff_c[i][W-1:0];
        dmag_s[i] <= dmag_s[i-1];
      end
      data_o_tdata  <= res_c;
      data_o_tvalid <= v_s[NS];
      div_zero_o    <= v_s[NS] & zero_s[NS];
    end
  end

endmodule

// File: tb/tb_stream_divider.sv
// Directed and streaming checks for stream_divider at DATA_WIDTH=16.
module tb_stream_divider;

  localparam int W = 16;
`ifdef STREAM_DIVIDER_ROUND_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = W + 1;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [W-1:0]  data_0_i_tdata = '0;
  logic          data_0_i_tvalid = 1'b0;
  logic [W-1:0]  data_1_i_tdata = '0;
  logic          data_1_i_tvalid = 1'b0;
  logic [W-1:0]  data_o_tdata;
  logic          data_o_tvalid;
  logic          div_zero_o;

  int   n_vec = 0;
  int   n_err = 0;
  logic mon_en = 1'b0;
  logic chk_rst = 1'b0;

  logic         ev [1:LAT];
  logic [W-1:0] ed [1:LAT];
  logic         ez [1:LAT];

  always #5 clk = ~clk;

  stream_divider #(.DATA_WIDTH(W)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_0_i_tdata  (data_0_i_tdata),
    .data_0_i_tvalid (data_0_i_tvalid),
    .data_1_i_tdata  (data_1_i_tdata),
    .data_1_i_tvalid (data_1_i_tvalid),
    .data_o_tdata    (data_o_tdata),
    .data_o_tvalid   (data_o_tvalid),
    .div_zero_o      (div_zero_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_div(input logic [W-1:0] n, input logic [W-1:0] d);
    longint sn, sd, an, ad, mag, q;
    sn = longint'($signed(n));
    sd = longint'($signed(d));
    if (sd == 0) return (sn >= 0) ? 16'h7FFF : 16'h8000;
    an = (sn < 0) ? -sn : sn;
    ad = (sd < 0) ? -sd : sd;
`ifdef STREAM_DIVIDER_ROUND_EN
    mag = (((an << 16) / ad) + 1) >> 1;
`else
    mag = (an << 15) / ad;
`endif
    q = ((sn < 0) != (sd < 0)) ? -mag : mag;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q[W-1:0];
  endfunction

  // Expected-output delay line, cleared by reset like the DUT.
  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 1; i <= LAT; i++) begin
        ev[i] <= 1'b0;
        ed[i] <= '0;
        ez[i] <= 1'b0;
      end
      chk_rst <= 1'b1;
    end else begin
      ev[1] <= data_0_i_tvalid & data_1_i_tvalid;
      ed[1] <= ref_div(data_0_i_tdata, data_1_i_tdata);
      ez[1] <= (data_1_i_tdata == '0);
      for (int i = 2; i <= LAT; i++) begin
        ev[i] <= ev[i-1];
        ed[i] <= ed[i-1];
        ez[i] <= ez[i-1];
      end
      chk_rst <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("valid", 32'(data_o_tvalid), 32'(ev[LAT]));
      if (ev[LAT]) begin
        check("data", 32'(data_o_tdata), 32'(ed[LAT]));
        check("div_zero", 32'(div_zero_o), 32'(ez[LAT]));
      end else begin
        check("div_zero_idle", 32'(div_zero_o), 32'd0);
      end
      if (chk_rst) check("rst_data", 32'(data_o_tdata), 32'd0);
    end
  end

  task automatic send(input string tag, input logic [W-1:0] n, input logic [W-1:0] d,
                      input logic [W-1:0] eq, input logic ez_exp);
    int  k;
    bit  found;
    @(posedge clk); #1;
    data_0_i_tdata = n;
    data_1_i_tdata = d;
    data_0_i_tvalid = 1'b1;
    data_1_i_tvalid = 1'b1;
    @(posedge clk); #1;
    data_0_i_tvalid = 1'b0;
    data_1_i_tvalid = 1'b0;
    found = 0;
    k = 1;
    while (!found && k <= LAT + 8) begin
      @(negedge clk);
      if (data_o_tvalid) found = 1;
      else k++;
    end
    check({tag, ":lat"}, 32'(k), 32'(LAT));
    if (found) begin
      check({tag, ":q"}, 32'(data_o_tdata), 32'(eq));
      check({tag, ":dz"}, 32'(div_zero_o), 32'(ez_exp));
      @(negedge clk);
      check({tag, ":one_beat"}, 32'(data_o_tvalid), 32'd0);
    end
  endtask

  initial begin
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    mon_en = 1'b1;
    @(posedge clk); #1;
    resetn = 1'b1;

    send("half",      16'h2000, 16'h4000, 16'h4000, 1'b0);
    send("neg_half",  16'hE000, 16'h4000, 16'hC000, 1'b0);
    send("nn_half",   16'hE000, 16'hC000, 16'h4000, 1'b0);
    send("zero_num",  16'h0000, 16'h0005, 16'h0000, 1'b0);
    send("sat_pos",   16'h4000, 16'h2000, 16'h7FFF, 1'b0);
    send("exact_m1",  16'h4000, 16'hC000, 16'h8000, 1'b0);
    send("n_eq_d",    16'h4000, 16'h4000, 16'h7FFF, 1'b0);
    send("min_min",   16'h8000, 16'h8000, 16'h7FFF, 1'b0);
    send("min_max",   16'h8000, 16'h7FFF, 16'h8000, 1'b0);
    send("dz_pos",    16'h1234, 16'h0000, 16'h7FFF, 1'b1);
    send("dz_neg",    16'hFFFB, 16'h0000, 16'h8000, 1'b1);
    send("dz_zero",   16'h0000, 16'h0000, 16'h7FFF, 1'b1);
`ifdef STREAM_DIVIDER_ROUND_EN
    send("third",     16'h0001, 16'h0003, 16'h2AAB, 1'b0);
    send("neg_third", 16'hFFFF, 16'h0003, 16'hD555, 1'b0);
`else
    send("third",     16'h0001, 16'h0003, 16'h2AAA, 1'b0);
    send("neg_third", 16'hFFFF, 16'h0003, 16'hD556, 1'b0);
`endif

    // Back-to-back stream with mixed valid patterns; the monitor checks every cycle.
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      data_0_i_tdata = W'($urandom);
      data_1_i_tdata = W'($urandom);
      if (i == 20) data_1_i_tdata = '0;
      if (i == 30) data_0_i_tdata = 16'h8000;
      if (i == 40) data_1_i_tdata = data_0_i_tdata;
      case (i % 8)
        1: begin data_0_i_tvalid = 1'b1; data_1_i_tvalid = 1'b0; end
        2: begin data_0_i_tvalid = 1'b0; data_1_i_tvalid = 1'b1; end
        3: begin data_0_i_tvalid = 1'b0; data_1_i_tvalid = 1'b0; end
        5: begin
          data_0_i_tvalid = 1'($urandom_range(0, 1));
          data_1_i_tvalid = 1'($urandom_range(0, 1));
        end
        default: begin data_0_i_tvalid = 1'b1; data_1_i_tvalid = 1'b1; end
      endcase
    end
    @(posedge clk); #1;
    data_0_i_tvalid = 1'b0;
    data_1_i_tvalid = 1'b0;
    repeat (LAT + 3) @(posedge clk);

    // Reset with ten beats in flight; nothing stale may emerge afterwards.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      data_0_i_tdata = W'($urandom);
      data_1_i_tdata = W'($urandom);
      data_0_i_tvalid = 1'b1;
      data_1_i_tvalid = 1'b1;
    end
    @(posedge clk); #1;
    data_0_i_tvalid = 1'b0;
    data_1_i_tvalid = 1'b0;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (LAT + 3) @(posedge clk);
    send("post_rst", 16'h2000, 16'h4000, 16'h4000, 1'b0);

    repeat (3) @(posedge clk);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
